// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the FIFO-to-UART drain sequencer: FSM encoding and default
// frame/separator settings.
package uart_fifo_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_Q  = 3'd1,
      LOAD    = 3'd2,
      WAIT_HI = 3'd3,
      WAIT_LO = 3'd4
   } drain_state_e;

   localparam logic [7:0]  DEFAULT_SEP_BYTE        = 8'h0A;
   localparam int unsigned DEFAULT_BYTES_PER_FRAME = 4;
   localparam int unsigned DEFAULT_BUSY_TIMEOUT    = 64;

endpackage

// File: rtl/uart_busy_timer.sv
// Watchdog for the transmitter handshake: restarted by each load strobe, raises expired
// so that the sequencer can flag a timeout exactly TIMEOUT clocks after the strobe.
module uart_busy_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk_50,
   input  logic clr,
   input  logic load_i,
   output logic expired_o
);

   // The FSM registers the error one clock after expired, so expiry fires at TIMEOUT-1.
   localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = 16'd1;
      end else if ((cnt_q != 16'd0) && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_50) begin
      if (clr) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_fifo_drain_ctrl.sv
// Sequencer that pops bytes from the sample FIFO, hands each one to the UART transmitter,
// waits out its busy window and optionally appends a separator after every frame.
module uart_fifo_drain_ctrl
   import uart_fifo_pkg::*;
#(
   parameter int unsigned RD_LATENCY      = 1,
   parameter int unsigned BYTES_PER_FRAME = DEFAULT_BYTES_PER_FRAME,
   parameter bit          SEP_EN          = 1'b1,
   parameter logic [7:0]  SEP_BYTE        = DEFAULT_SEP_BYTE,
   parameter int unsigned BUSY_TIMEOUT    = DEFAULT_BUSY_TIMEOUT
) (
   input  logic        clk_50,
   input  logic        clr,
   input  logic        enable,
   input  logic        fifo_rdempty,
   input  logic [7:0]  fifo_q,
   output logic        fifo_rdreq,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_wr_en,
   output logic        active,
   output logic [15:0] sent_count,
   output logic        err_timeout
);

   localparam logic [1:0] LAT_LAST   = 2'(RD_LATENCY);
   localparam logic [7:0] FRAME_LAST = 8'(BYTES_PER_FRAME - 1);

   drain_state_e state_q, state_d;
   logic         rdreq_q, rdreq_d;
   logic         wr_en_q, wr_en_d;
   logic [7:0]   tx_data_q, tx_data_d;
   logic         active_q, active_d;
   logic [15:0]  sent_count_q, sent_count_d;
   logic         err_q, err_d;
   logic [7:0]   frame_cnt_q, frame_cnt_d;
   logic         sep_pending_q, sep_pending_d;
   logic         is_sep_q, is_sep_d;
   logic [1:0]   lat_cnt_q, lat_cnt_d;
   logic         timer_expired;

   uart_busy_timer #(
      .TIMEOUT (BUSY_TIMEOUT)
   ) u_busy_timer (
      .clk_50    (clk_50),
      .clr       (clr),
      .load_i    (wr_en_q),
      .expired_o (timer_expired)
   );

   // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
   always_comb begin
      state_d       = state_q;
      rdreq_d       = 1'b0;
      wr_en_d       = 1'b0;
      tx_data_d     = tx_data_q;
      sent_count_d  = sent_count_q;
      err_d         = err_q;
      frame_cnt_d   = frame_cnt_q;
      sep_pending_d = sep_pending_q;
      is_sep_d      = is_sep_q;
      lat_cnt_d     = lat_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (sep_pending_q && enable) begin
               tx_data_d = SEP_BYTE;
               is_sep_d  = 1'b1;
               wr_en_d   = !tx_busy;
               state_d   = LOAD;
            end else if (enable && !fifo_rdempty) begin
               rdreq_d   = 1'b1;
               lat_cnt_d = 2'd0;
               state_d   = WAIT_Q;
            end
         end
         WAIT_Q: begin
            // Capturing and arming the strobe on the same edge gives rdreq-to-wr_en = RD_LATENCY+1.
            if (lat_cnt_q == LAT_LAST) begin
               tx_data_d = fifo_q;
               is_sep_d  = 1'b0;
               wr_en_d   = !tx_busy;
               state_d   = LOAD;
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end
         LOAD: begin
            if (wr_en_q) begin
               state_d = WAIT_HI;
            end else if (!tx_busy) begin
               wr_en_d = 1'b1;
            end
         end
         WAIT_HI: begin
            if (tx_busy) begin
               state_d = WAIT_LO;
            end else if (timer_expired) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               state_d = IDLE;
               if (is_sep_q) begin
                  sep_pending_d = 1'b0;
               end else begin
                  sent_count_d = sent_count_q + 16'd1;
                  if (frame_cnt_q == FRAME_LAST) begin
                     frame_cnt_d   = 8'd0;
                     sep_pending_d = SEP_EN;
                  end else begin
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      active_d = (state_d != IDLE);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_50) begin
      if (clr) begin
         state_q       <= IDLE;
         rdreq_q       <= 1'b0;
         wr_en_q       <= 1'b0;
         tx_data_q     <= 8'h00;
         active_q      <= 1'b0;
         sent_count_q  <= 16'h0000;
         err_q         <= 1'b0;
         frame_cnt_q   <= 8'd0;
         sep_pending_q <= 1'b0;
         is_sep_q      <= 1'b0;
         lat_cnt_q     <= 2'd0;
      end else begin
         state_q       <= state_d;
         rdreq_q       <= rdreq_d;
         wr_en_q       <= wr_en_d;
         tx_data_q     <= tx_data_d;
         active_q      <= active_d;
         sent_count_q  <= sent_count_d;
         err_q         <= err_d;
         frame_cnt_q   <= frame_cnt_d;
         sep_pending_q <= sep_pending_d;
         is_sep_q      <= is_sep_d;
         lat_cnt_q     <= lat_cnt_d;
      end
   end

   assign fifo_rdreq  = rdreq_q;
   assign tx_wr_en    = wr_en_q;
   assign tx_data     = tx_data_q;
   assign active      = active_q;
   assign sent_count  = sent_count_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_fifo_drain_ctrl.sv
// Directed bench for uart_fifo_drain_ctrl: instance A uses default parameters, instance B
// uses RD_LATENCY=2 with the separator disabled.
module tb_uart_fifo_drain_ctrl;

   logic clk_50 = 1'b0;
   always #10 clk_50 = ~clk_50;

   logic        a_clr, a_enable, a_rdempty, a_rdreq, a_busy, a_wr_en, a_active, a_err;
   logic [7:0]  a_q, a_tx_data;
   logic [15:0] a_sent;
   logic        b_clr, b_enable, b_rdempty, b_rdreq, b_busy, b_wr_en, b_active, b_err;
   logic [7:0]  b_q, b_tx_data;
   logic [15:0] b_sent;

   uart_fifo_drain_ctrl u_dut_a (
      .clk_50(clk_50), .clr(a_clr), .enable(a_enable), .fifo_rdempty(a_rdempty),
      .fifo_q(a_q), .fifo_rdreq(a_rdreq), .tx_busy(a_busy), .tx_data(a_tx_data),
      .tx_wr_en(a_wr_en), .active(a_active), .sent_count(a_sent), .err_timeout(a_err)
   );

   uart_fifo_drain_ctrl #(.RD_LATENCY(2), .SEP_EN(1'b0)) u_dut_b (
      .clk_50(clk_50), .clr(b_clr), .enable(b_enable), .fifo_rdempty(b_rdempty),
      .fifo_q(b_q), .fifo_rdreq(b_rdreq), .tx_busy(b_busy), .tx_data(b_tx_data),
      .tx_wr_en(b_wr_en), .active(b_active), .sent_count(b_sent), .err_timeout(b_err)
   );

   // FIFO models: A returns q one clock after rdreq, B two clocks after.
   logic [7:0] a_mem [0:63];
   logic [7:0] b_mem [0:63];
   int a_wr_ptr = 0, a_rd_ptr = 0, b_wr_ptr = 0, b_rd_ptr = 0;
   logic [7:0] a_p1, b_p1, b_p2;
   assign a_rdempty = (a_wr_ptr == a_rd_ptr);
   assign b_rdempty = (b_wr_ptr == b_rd_ptr);
   assign a_q = a_p1;
   assign b_q = b_p2;

   always @(posedge clk_50) begin
      if (a_rdreq) begin
         a_p1     <= a_mem[a_rd_ptr];
         a_rd_ptr <= a_rd_ptr + 1;
      end
      if (b_rdreq) begin
         b_p1     <= b_mem[b_rd_ptr];
         b_rd_ptr <= b_rd_ptr + 1;
      end
      b_p2 <= b_p1;
   end

   // Transmitter models: busy rises 2 clocks after wr_en and stays high for 10 clocks.
   bit a_busy_en = 1'b0, b_busy_en = 1'b0;
   int a_bcnt = 0, b_bcnt = 0;
   always @(posedge clk_50) begin
      if (a_busy_en && a_wr_en)  a_bcnt <= 1;
      else if (a_bcnt == 11)     a_bcnt <= 0;
      else if (a_bcnt != 0)      a_bcnt <= a_bcnt + 1;
      if (b_busy_en && b_wr_en)  b_bcnt <= 1;
      else if (b_bcnt == 11)     b_bcnt <= 0;
      else if (b_bcnt != 0)      b_bcnt <= b_bcnt + 1;
   end
   assign a_busy = (a_bcnt >= 2);
   assign b_busy = (b_bcnt >= 2);

   // Monitor: logs every load strobe and pop with its cycle number.
   int cyc = 0;
   logic [7:0] a_log [0:31];
   logic [7:0] b_log [0:31];
   int a_wr_cyc [0:31];
   int a_rd_cyc [0:31];
   int b_wr_cyc [0:31];
   int b_rd_cyc [0:31];
   int a_nwr = 0, a_nrd = 0, b_nwr = 0, b_nrd = 0;
   int overlap = 0, underflow = 0, a_err_cyc = -1;
   always @(posedge clk_50) begin
      cyc <= cyc + 1;
      if (a_wr_en) begin
         a_log[a_nwr]    <= a_tx_data;
         a_wr_cyc[a_nwr] <= cyc;
         a_nwr           <= a_nwr + 1;
      end
      if (a_rdreq) begin
         a_rd_cyc[a_nrd] <= cyc;
         a_nrd           <= a_nrd + 1;
      end
      if (b_wr_en) begin
         b_log[b_nwr]    <= b_tx_data;
         b_wr_cyc[b_nwr] <= cyc;
         b_nwr           <= b_nwr + 1;
      end
      if (b_rdreq) begin
         b_rd_cyc[b_nrd] <= cyc;
         b_nrd           <= b_nrd + 1;
      end
      if ((a_rdreq && a_wr_en) || (b_rdreq && b_wr_en)) overlap <= overlap + 1;
      if ((a_rdreq && a_rdempty) || (b_rdreq && b_rdempty)) underflow <= underflow + 1;
      if (a_err && (a_err_cyc < 0)) a_err_cyc <= cyc;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   initial begin
      logic [7:0] frame_a [0:3];
      int         to_idx;
      frame_a[0] = 8'hDE; frame_a[1] = 8'hAD; frame_a[2] = 8'hBE; frame_a[3] = 8'hEF;

      // 1: reset and idle with an empty FIFO
      a_clr = 1'b1; b_clr = 1'b1; a_enable = 1'b1; b_enable = 1'b1;
      tick(2);
      check("rst_rdreq", 32'(a_rdreq), 32'd0);
      check("rst_wr_en", 32'(a_wr_en), 32'd0);
      check("rst_tx_data", 32'(a_tx_data), 32'h00);
      check("rst_active", 32'(a_active), 32'd0);
      check("rst_sent", 32'(a_sent), 32'd0);
      check("rst_err", 32'(a_err), 32'd0);
      a_clr = 1'b0; b_clr = 1'b0;
      tick(100);
      check("idle_pops_a", 32'(a_nrd), 32'd0);
      check("idle_loads_a", 32'(a_nwr), 32'd0);
      check("idle_active_a", 32'(a_active), 32'd0);
      check("idle_pops_b", 32'(b_nrd), 32'd0);
      check("idle_active_b", 32'(b_active), 32'd0);

      // 2: one frame DE AD BE EF followed by the separator
      a_busy_en = 1'b1;
      for (int i = 0; i < 4; i++) a_mem[i] = frame_a[i];
      a_wr_ptr = 4;
      for (int i = 0; i < 400 && !(a_nwr == 5 && !a_active); i++) tick(1);
      check("frame_loads", 32'(a_nwr), 32'd5);
      for (int i = 0; i < 4; i++) check($sformatf("frame_byte%0d", i), 32'(a_log[i]), 32'(frame_a[i]));
      check("frame_sep", 32'(a_log[4]), 32'h0A);
      check("frame_sent", 32'(a_sent), 32'd4);
      check("frame_pops", 32'(a_nrd), 32'd4);
      check("latency_l1", 32'(a_wr_cyc[0] - a_rd_cyc[0]), 32'd2);
      check("frame_err", 32'(a_err), 32'd0);

      // 5: enable dropped while the 4th byte of the next frame is in flight
      a_mem[4] = 8'h11; a_mem[5] = 8'h22; a_mem[6] = 8'h33; a_mem[7] = 8'h44;
      a_wr_ptr = 8;
      for (int i = 0; i < 300 && !(a_nwr == 9 && a_busy); i++) tick(1);
      tick(1);
      a_enable = 1'b0;
      a_mem[8] = 8'h55;
      a_wr_ptr = 9;
      tick(30);
      check("dis_loads", 32'(a_nwr), 32'd9);
      check("dis_last_byte", 32'(a_log[8]), 32'h44);
      check("dis_sent", 32'(a_sent), 32'd8);
      check("dis_active", 32'(a_active), 32'd0);
      check("dis_pops", 32'(a_nrd), 32'd8);
      a_enable = 1'b1;
      for (int i = 0; i < 200 && !(a_nwr == 11 && !a_active); i++) tick(1);
      check("reen_sep_first", 32'(a_log[9]), 32'h0A);
      check("reen_data", 32'(a_log[10]), 32'h55);
      check("reen_sent", 32'(a_sent), 32'd9);

      // 4: transmitter never goes busy
      a_clr = 1'b1;
      tick(1);
      a_clr = 1'b0;
      a_busy_en = 1'b0;
      check("clr_sent", 32'(a_sent), 32'd0);
      a_mem[9] = 8'h77;
      a_wr_ptr = 10;
      to_idx = 11;
      for (int i = 0; i < 300 && a_err_cyc < 0; i++) tick(1);
      check("to_err", 32'(a_err), 32'd1);
      check("to_byte", 32'(a_log[to_idx]), 32'h77);
      check("to_delay", 32'(a_err_cyc - a_wr_cyc[to_idx]), 32'd64);
      check("to_sent", 32'(a_sent), 32'd0);
      tick(50);
      check("to_sticky", 32'(a_err), 32'd1);
      check("to_idle", 32'(a_active), 32'd0);
      check("to_no_retry", 32'(a_nwr), 32'd12);
      a_clr = 1'b1;
      tick(1);
      a_clr = 1'b0;
      check("to_clr", 32'(a_err), 32'd0);

      // 3: separator disabled, six bytes, RD_LATENCY=2
      b_busy_en = 1'b1;
      for (int i = 0; i < 6; i++) b_mem[i] = 8'(i + 1);
      b_wr_ptr = 6;
      for (int i = 0; i < 600 && !(b_nwr == 6 && !b_active); i++) tick(1);
      tick(30);
      check("nosep_loads", 32'(b_nwr), 32'd6);
      for (int i = 0; i < 6; i++) check($sformatf("nosep_byte%0d", i), 32'(b_log[i]), 32'(i + 1));
      check("nosep_sent", 32'(b_sent), 32'd6);
      check("nosep_pops", 32'(b_nrd), 32'd6);
      check("latency_l2", 32'(b_wr_cyc[0] - b_rd_cyc[0]), 32'd3);

      // 6: clr during WAIT_HI with the counter at FFFF, then wrap FFFF -> 0000
      force u_dut_b.sent_count_q = 16'hFFFF;
      tick(1);
      release u_dut_b.sent_count_q;
      tick(1);
      check("preset_ffff", 32'(b_sent), 32'hFFFF);
      b_mem[6] = 8'h5A;
      b_wr_ptr = 7;
      for (int i = 0; i < 100 && b_wr_en !== 1'b1; i++) tick(1);
      check("clr_wr_seen", 32'(b_wr_en), 32'd1);
      tick(1);
      check("clr_in_wait_hi", 32'(b_active), 32'd1);
      b_clr = 1'b1;
      tick(1);
      check("clr_active", 32'(b_active), 32'd0);
      check("clr_wr_en", 32'(b_wr_en), 32'd0);
      check("clr_sent_b", 32'(b_sent), 32'd0);
      check("clr_tx_data", 32'(b_tx_data), 32'h00);
      b_clr = 1'b0;
      tick(15);
      check("clr_stays_idle", 32'(b_active), 32'd0);
      force u_dut_b.sent_count_q = 16'hFFFF;
      tick(1);
      release u_dut_b.sent_count_q;
      tick(1);
      check("wrap_preset", 32'(b_sent), 32'hFFFF);
      b_mem[7] = 8'hC3;
      b_wr_ptr = 8;
      for (int i = 0; i < 200 && !(b_nwr == 8 && !b_active); i++) tick(1);
      check("wrap_byte", 32'(b_log[7]), 32'hC3);
      check("wrap_sent", 32'(b_sent), 32'h0000);

      check("never_overlap", 32'(overlap), 32'd0);
      check("never_underflow", 32'(underflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
